// File: rtl/bitserial_cmp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bitserial_cmp_ctrl_pkg
// Brief    : Shared state and result encodings for the bit-serial comparator.
// Revision : 1.0 - initial release
// ============================================================================
package bitserial_cmp_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One-hot result vector, ordered {gt, eq, lt}
  localparam logic [2:0] C_RES_NONE = 3'b000;
  localparam logic [2:0] C_RES_GT   = 3'b100;
  localparam logic [2:0] C_RES_EQ   = 3'b010;
  localparam logic [2:0] C_RES_LT   = 3'b001;

endpackage
`default_nettype wire

// File: rtl/bitserial_cmp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bitserial_cmp_ctrl_if
// Brief    : Request/result bundle of the bit-serial comparator controller.
// Revision : 1.0 - initial release
// ============================================================================
interface bitserial_cmp_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [CW-1:0]    bits_used;

  modport master (
    output start, a_in, b_in,
    input  busy, done, gt, eq, lt, bits_used
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, gt, eq, lt, bits_used
  );

endinterface
`default_nettype wire

// File: rtl/bitserial_cmp_ctrl_cmp1_cell.sv
`default_nettype none
// ============================================================================
// Module   : cmp1_cell
// Brief    : Purely combinational 1-bit magnitude comparator.
// Revision : 1.0 - initial release
// ============================================================================
module cmp1_cell (
  input  wire logic i_a,
  input  wire logic i_b,
  output logic      o_gt,
  output logic      o_eq,
  output logic      o_lt
);

  assign o_gt = i_a & ~i_b;
  assign o_lt = ~i_a & i_b;
  assign o_eq = ~(i_a ^ i_b);

endmodule
`default_nettype wire

// File: rtl/bitserial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bitserial_cmp_ctrl
// Brief    : Feeds two operands MSB-first through one 1-bit comparator cell.
// Revision : 1.0 - initial release
// ============================================================================
module bitserial_cmp_ctrl
  import bitserial_cmp_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  bitserial_cmp_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_bits_used;
  logic             r_decided;
  logic [2:0]       r_res;

  logic             w_gt;
  logic             w_eq;
  logic             w_lt;
  logic             w_last;
  logic             w_finish;

  cmp1_cell u_cell (
    .i_a  (r_sa[WIDTH-1]),
    .i_b  (r_sb[WIDTH-1]),
    .o_gt (w_gt),
    .o_eq (w_eq),
    .o_lt (w_lt)
  );

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_finish = w_last | (EARLY_EXIT & ~w_eq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_finish)  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa        <= '0;
      r_sb        <= '0;
      r_cnt       <= '0;
      r_bits_used <= '0;
      r_decided   <= 1'b0;
      r_res       <= C_RES_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sa      <= bus.a_in;
            r_sb      <= bus.b_in;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_res     <= C_RES_NONE;
          end
        end
        S_SHIFT: begin
          r_sa  <= r_sa << 1;
          r_sb  <= r_sb << 1;
          r_cnt <= r_cnt + 1'b1;
          // Only the first unequal bit (from the MSB) decides the result
          if (!w_eq && !r_decided) begin
            r_res     <= w_gt ? C_RES_GT : C_RES_LT;
            r_decided <= 1'b1;
          end
          if (w_finish) begin
            r_bits_used <= (EARLY_EXIT && !w_eq) ? r_cnt + 1'b1 : CW'(WIDTH);
            if (w_last && w_eq && !r_decided) begin
              r_res <= C_RES_EQ;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.gt        = r_res[2];
  assign bus.eq        = r_res[1];
  assign bus.lt        = r_res[0];
  assign bus.bits_used = r_bits_used;

  // w_lt is implied by r_res encoding but kept on the cell for completeness
  logic w_unused;
  assign w_unused = w_lt;

endmodule
`default_nettype wire

// File: tb/tb_bitserial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitserial_cmp_ctrl
// Brief    : Self-checking bench for three comparator configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitserial_cmp_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Index 0: WIDTH=8 early exit, 1: WIDTH=8 full run, 2: WIDTH=1
  logic       t_start [3];
  logic [7:0] t_a     [3];
  logic [7:0] t_b     [3];
  logic       o_busy  [3];
  logic       o_done  [3];
  logic [2:0] o_res   [3];
  logic [3:0] o_bits  [3];

  bitserial_cmp_ctrl_if #(.WIDTH(8)) if0 ();
  bitserial_cmp_ctrl_if #(.WIDTH(8)) if1 ();
  bitserial_cmp_ctrl_if #(.WIDTH(1)) if2 ();

  assign if0.start = t_start[0];
  assign if0.a_in  = t_a[0];
  assign if0.b_in  = t_b[0];
  assign if1.start = t_start[1];
  assign if1.a_in  = t_a[1];
  assign if1.b_in  = t_b[1];
  assign if2.start = t_start[2];
  assign if2.a_in  = t_a[2][0];
  assign if2.b_in  = t_b[2][0];

  assign o_busy[0] = if0.busy;
  assign o_done[0] = if0.done;
  assign o_res[0]  = {if0.gt, if0.eq, if0.lt};
  assign o_bits[0] = if0.bits_used;
  assign o_busy[1] = if1.busy;
  assign o_done[1] = if1.done;
  assign o_res[1]  = {if1.gt, if1.eq, if1.lt};
  assign o_bits[1] = if1.bits_used;
  assign o_busy[2] = if2.busy;
  assign o_done[2] = if2.done;
  assign o_res[2]  = {if2.gt, if2.eq, if2.lt};
  assign o_bits[2] = {3'b000, if2.bits_used};

  bitserial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  bitserial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  bitserial_cmp_ctrl #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // Reference: scan bits from the MSB for the first difference
  task automatic model(input logic [7:0] a, input logic [7:0] b, input int w, input bit ee,
                       output logic [2:0] res, output int bits);
    int first;
    logic [7:0] ma;
    logic [7:0] mb;
    ma = a & 8'((1 << w) - 1);
    mb = b & 8'((1 << w) - 1);
    first = -1;
    for (int i = w - 1; i >= 0; i--) begin
      if (first < 0 && ma[i] != mb[i]) first = w - 1 - i;
    end
    if (ma > mb)      res = 3'b100;
    else if (ma < mb) res = 3'b001;
    else              res = 3'b010;
    bits = (ee && first >= 0) ? first + 1 : w;
  endtask

  task automatic op(input int d, input logic [7:0] a, input logic [7:0] b, input bit pester);
    int w;
    int exp_bits;
    int cyc;
    logic [2:0] exp_res;
    w = (d == 2) ? 1 : 8;
    model(a, b, w, d != 1, exp_res, exp_bits);
    @(negedge clk);
    t_a[d] = a;
    t_b[d] = b;
    t_start[d] = 1'b1;
    @(posedge clk); #1;
    t_start[d] = pester;
    t_a[d] = pester ? 8'h00 : 8'($urandom);
    t_b[d] = pester ? 8'hFF : 8'($urandom);
    chk("busy_rise", d, 32'(o_busy[d]), 32'd1);
    chk("res_cleared", d, 32'(o_res[d]), 32'd0);
    cyc = 1;
    while (o_done[d] !== 1'b1 && cyc < w + 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    t_start[d] = 1'b0;
    chk("done_seen", d, 32'(o_done[d]), 32'd1);
    chk("latency", d, 32'(cyc), 32'(exp_bits + 1));
    chk("result", d, 32'(o_res[d]), 32'(exp_res));
    chk("bits_used", d, 32'(o_bits[d]), 32'(exp_bits));
    @(posedge clk); #1;
    chk("done_pulse", d, 32'(o_done[d]), 32'd0);
    chk("back_idle", d, 32'(o_busy[d]), 32'd0);
    @(posedge clk); #1;
    chk("no_requeue", d, 32'(o_busy[d] | o_done[d]), 32'd0);
    chk("res_held", d, 32'(o_res[d]), 32'(exp_res));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      t_start[i] = 1'b0;
      t_a[i] = 8'h00;
      t_b[i] = 8'h00;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, 32'(o_busy[i]), 32'd0);
      chk("rst_done", i, 32'(o_done[i]), 32'd0);
      chk("rst_res", i, 32'(o_res[i]), 32'd0);
      chk("rst_bits", i, 32'(o_bits[i]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    op(0, 8'hA5, 8'hA5, 1'b0);
    op(0, 8'h80, 8'h7F, 1'b0);
    op(0, 8'h12, 8'h13, 1'b0);
    op(0, 8'h3C, 8'h35, 1'b1);

    // Abort a compare with an async reset in its fourth cycle
    @(negedge clk);
    t_a[0] = 8'h01;
    t_b[0] = 8'h00;
    t_start[0] = 1'b1;
    @(posedge clk); #1;
    t_start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 0, 32'(o_busy[0]), 32'd0);
    chk("abort_res", 0, 32'(o_res[0]), 32'd0);
    chk("abort_bits", 0, 32'(o_bits[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 0, 32'(o_done[0] | o_busy[0]), 32'd0);
    end
    op(0, 8'h01, 8'h00, 1'b0);

    op(1, 8'h80, 8'h7F, 1'b0);
    op(1, 8'h5A, 8'h5A, 1'b0);
    op(2, 8'h01, 8'h00, 1'b0);
    op(2, 8'h00, 8'h00, 1'b0);
    op(2, 8'h00, 8'h01, 1'b1);

    for (int n = 0; n < 24; n++) begin
      int d;
      logic [7:0] ra;
      logic [7:0] rb;
      d  = int'($urandom_range(0, 2));
      ra = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ 8'(1 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      op(d, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
